// File: rtl/mac_seq_ctrl.sv
// Sequencer/accumulator feeding a 16x16 shift-add multiplier: takes a bias job, streams
// (x,w) pairs through the multiplier and emits one saturating pre-activation sum per job.
module mac_seq_ctrl #(
    parameter int ACC_W       = 40,
    parameter int CNT_W       = 10,
    parameter int MUL_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_w,
    input  logic             in_last,
    output logic             mul_start,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [31:0]      mul_y,
    input  logic             mul_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int              TMO_W    = $clog2(MUL_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [ACC_W:0]   sum_wide;

    // One extra bit catches the carry that signals saturation.
    assign sum_wide = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(mul_y);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        err_d   = err_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    acc_d   = ACC_W'(cmd_bias);
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    a_d     = in_x;
                    b_d     = in_w;
                    last_d  = in_last;
                    tmo_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                // A completing product takes priority over a timeout in the same cycle.
                if (mul_done) begin
                    if (sum_wide[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_wide[ACC_W-1:0];
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    tmo_d   = '0;
                    state_d = last_q ? S_OUT : S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_OUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them without delay.
    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_FETCH);
    assign mul_start = (state_q == S_MUL);
    assign out_valid = (state_q == S_OUT);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a 40-bit and a 32-bit accumulator instance share stimulus and a
// behavioural multiplier; job results are compared against a sum-and-clamp reference.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_bias = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0;
    logic [15:0] in_w = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] mul_y;
    logic        mul_done;

    logic        cmd_ready, in_ready, mul_start, out_valid, out_sat, out_err;
    logic [15:0] mul_a, mul_b;
    logic [39:0] out_sum;
    logic [9:0]  out_count;
    logic        cmd_ready_s, in_ready_s, mul_start_s, out_valid_s, out_sat_s, out_err_s;
    logic [15:0] mul_a_s, mul_b_s;
    logic [31:0] out_sum_s;
    logic [9:0]  out_count_s;

    mac_seq_ctrl #(.ACC_W(40), .CNT_W(10), .MUL_TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_bias(cmd_bias), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_w(in_w), .in_last(in_last), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .mul_done(mul_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_sat(out_sat), .out_err(out_err), .out_count(out_count)
    );

    mac_seq_ctrl #(.ACC_W(32), .CNT_W(10), .MUL_TIMEOUT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_bias(cmd_bias), .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x),
        .in_w(in_w), .in_last(in_last), .mul_start(mul_start_s), .mul_a(mul_a_s),
        .mul_b(mul_b_s), .mul_y(mul_y), .mul_done(mul_done), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_sat(out_sat_s), .out_err(out_err_s),
        .out_count(out_count_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: done arrives in the done_cycle-th cycle of mul_start.
    int          mcnt = 0;
    int          done_cycle = 18;
    logic        never_done = 1'b0;
    logic        force_y_en = 1'b0;
    logic [31:0] force_y = '0;
    always @(posedge clk) begin
        if (!mul_start) mcnt <= 0;
        else            mcnt <= mcnt + 1;
    end
    assign mul_done = mul_start && !never_done && (mcnt == done_cycle - 1);
    assign mul_y    = force_y_en ? force_y : (32'(mul_a) * 32'(mul_b));

    // Operation monitor: counts multiplier starts and operand changes mid-operation.
    logic        mon_en = 1'b0;
    logic        ms_prev = 1'b0;
    int          mon_starts = 0;
    int          mon_unstable = 0;
    logic [15:0] a_hold = '0, b_hold = '0;
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_starts <= 0; mon_unstable <= 0; ms_prev <= 1'b0;
        end else begin
            if (mul_start && !ms_prev) begin
                mon_starts <= mon_starts + 1; a_hold <= mul_a; b_hold <= mul_b;
            end else if (mul_start && (mul_a !== a_hold || mul_b !== b_hold)) begin
                mon_unstable <= mon_unstable + 1;
            end
            ms_prev <= mul_start;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    int unsigned px[8], pw[8];
    int          gap[8];

    longint unsigned obs_sum, obs_sum_s;
    logic            obs_sat, obs_sat_s, obs_err, obs_err_s, obs_ms_out, obs_after_valid;
    int              obs_cnt, obs_cnt_s, obs_lat, obs_starts, obs_unstable, obs_accepted;
    int              obs_stall_bad;
    bit              obs_timeout;

    // Expected job outcome: bias plus every completed product, clamped to the accumulator range.
    function automatic void ref_job(input longint unsigned bias, input int n, input int acc_w,
                                    output longint unsigned sum, output bit sat, output int cnt);
        longint unsigned total = bias;
        longint unsigned maxv = (64'd1 << acc_w) - 64'd1;
        for (int i = 0; i < n; i++) total += longint'(px[i]) * longint'(pw[i]);
        sat = (total > maxv);
        sum = sat ? maxv : total;
        cnt = (n > 1023) ? 1023 : n;
    endfunction

    task automatic run_job(input logic [31:0] bias, input int n, input int stall);
        int waited;
        int hs_cyc;
        obs_timeout = 0; obs_lat = -1; obs_accepted = 0; obs_stall_bad = 0;
        mon_en = 1'b1;
        cmd_valid = 1'b1; cmd_bias = bias;
        waited = 0;
        while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
        if (!cmd_ready) begin obs_timeout = 1; cmd_valid = 1'b0; mon_en = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0;
        hs_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i] && !out_valid; g++) @(negedge clk);
            if (out_valid) break;
            in_valid = 1'b1; in_x = px[i][15:0]; in_w = pw[i][15:0]; in_last = (i == n - 1);
            waited = 0;
            while (!in_ready && !out_valid && waited < 100) begin @(negedge clk); waited++; end
            if (in_ready) begin
                if (i == 0) hs_cyc = cyc;
                obs_accepted++;
                @(negedge clk);
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b0;
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        waited = 0;
        while (!out_valid && waited < 300) begin @(negedge clk); waited++; end
        if (!out_valid) begin obs_timeout = 1; mon_en = 1'b0; return; end
        obs_lat = cyc - hs_cyc;
        obs_sum = 64'(out_sum); obs_sat = out_sat; obs_err = out_err; obs_cnt = out_count;
        obs_sum_s = 64'(out_sum_s); obs_sat_s = out_sat_s; obs_err_s = out_err_s;
        obs_cnt_s = out_count_s; obs_ms_out = mul_start;
        repeat (stall) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || 64'(out_sum) !== obs_sum || out_sat !== obs_sat ||
                out_err !== obs_err || int'(out_count) !== obs_cnt || 64'(out_sum_s) !== obs_sum_s)
                obs_stall_bad++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        obs_starts = mon_starts; obs_unstable = mon_unstable;
        obs_after_valid = out_valid;
        mon_en = 1'b0;
        @(negedge clk);
        $display("job bias=%08h pairs=%0d sum40=%0d sum32=%0d sat=%0d/%0d err=%0d cnt=%0d lat=%0d",
                 bias, obs_accepted, obs_sum, obs_sum_s, obs_sat, obs_sat_s, obs_err, obs_cnt, obs_lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if ({in_ready, mul_start, out_valid, out_sat, out_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {in_ready, mul_start, out_valid, out_sat, out_err}); end
        n_checks++; if (out_sum !== 40'd0 || out_count !== 10'd0) begin n_fail++; $display("FAIL reset_sum_count: got %0d/%0d want 0/0", out_sum, out_count); end
        n_checks++; if (mul_a !== 16'd0 || mul_b !== 16'd0) begin n_fail++; $display("FAIL reset_operands: got %0d/%0d want 0/0", mul_a, mul_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        px[0] = 3;     pw[0] = 5;
        px[1] = 100;   pw[1] = 200;
        px[2] = 65535; pw[2] = 65535;
        for (int i = 0; i < 8; i++) gap[i] = 0;
        run_job(32'd0, 3, 0);
        n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL basic_handshake: got timeout want completion"); end
        n_checks++; if (obs_sum !== 64'd4294856240) begin n_fail++; $display("FAIL basic_sum: got %0d want 4294856240", obs_sum); end
        n_checks++; if (obs_cnt !== 3 || obs_sat !== 1'b0 || obs_err !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got cnt=%0d sat=%b err=%b want 3/0/0", obs_cnt, obs_sat, obs_err); end
        n_checks++; if (obs_lat !== 57) begin n_fail++; $display("FAIL basic_latency: got %0d want 57", obs_lat); end
        n_checks++; if (obs_starts !== 3) begin n_fail++; $display("FAIL basic_starts: got %0d want 3", obs_starts); end
    endtask

    task automatic test_saturation();
        px[0] = 4; pw[0] = 5; gap[0] = 0;
        run_job(32'hFFFF_FFF0, 1, 0);
        n_checks++; if (obs_sum_s !== 64'hFFFF_FFFF || obs_sat_s !== 1'b1) begin n_fail++; $display("FAIL sat32: got sum=%0h sat=%b want ffffffff/1", obs_sum_s, obs_sat_s); end
        n_checks++; if (obs_sum !== 64'h1_0000_0004 || obs_sat !== 1'b0) begin n_fail++; $display("FAIL sat40_nosat: got sum=%0h sat=%b want 100000004/0", obs_sum, obs_sat); end
    endtask

    task automatic test_timeout();
        never_done = 1'b1;
        px[0] = 2; pw[0] = 2; gap[0] = 0;
        run_job(32'd7, 1, 0);
        never_done = 1'b0;
        n_checks++; if (obs_err !== 1'b1 || obs_err_s !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b/%b want 1/1", obs_err, obs_err_s); end
        n_checks++; if (obs_sum !== 64'd7 || obs_cnt !== 0) begin n_fail++; $display("FAIL tmo_sum_count: got %0d/%0d want 7/0", obs_sum, obs_cnt); end
        n_checks++; if (obs_lat !== 33) begin n_fail++; $display("FAIL tmo_latency: got %0d want 33", obs_lat); end
        n_checks++; if (obs_ms_out !== 1'b0) begin n_fail++; $display("FAIL tmo_mul_start_out: got %b want 0", obs_ms_out); end
    endtask

    task automatic test_done_vs_timeout();
        done_cycle = 32; force_y_en = 1'b1; force_y = 32'd9;
        px[0] = 3; pw[0] = 3; gap[0] = 0;
        run_job(32'd1, 1, 0);
        done_cycle = 18; force_y_en = 1'b0;
        n_checks++; if (obs_sum !== 64'd10 || obs_err !== 1'b0) begin n_fail++; $display("FAIL done_wins: got sum=%0d err=%b want 10/0", obs_sum, obs_err); end
        n_checks++; if (obs_cnt !== 1) begin n_fail++; $display("FAIL done_wins_count: got %0d want 1", obs_cnt); end
    endtask

    task automatic test_random_stall();
        longint unsigned e_sum, e_sum_s;
        bit              e_sat, e_sat_s;
        int              e_cnt, n;
        logic [31:0]     bias;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                px[i] = $urandom_range(0, 65535); pw[i] = $urandom_range(0, 65535);
                gap[i] = $urandom_range(0, 5);
            end
            bias = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 1 << 20))) : 32'($urandom);
            ref_job(64'(bias), n, 40, e_sum, e_sat, e_cnt);
            ref_job(64'(bias), n, 32, e_sum_s, e_sat_s, e_cnt);
            run_job(bias, n, 10);
            n_checks++; if (obs_timeout || obs_accepted !== n) begin n_fail++; $display("FAIL rnd%0d_accepted: got %0d want %0d", j, obs_accepted, n); end
            n_checks++; if (obs_sum !== e_sum || obs_sat !== e_sat) begin n_fail++; $display("FAIL rnd%0d_sum40: got %0d/%b want %0d/%b", j, obs_sum, obs_sat, e_sum, e_sat); end
            n_checks++; if (obs_sum_s !== e_sum_s || obs_sat_s !== e_sat_s) begin n_fail++; $display("FAIL rnd%0d_sum32: got %0d/%b want %0d/%b", j, obs_sum_s, obs_sat_s, e_sum_s, e_sat_s); end
            n_checks++; if (obs_cnt !== e_cnt || obs_cnt_s !== e_cnt || obs_err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_count: got %0d/%0d err=%b want %0d err=0", j, obs_cnt, obs_cnt_s, obs_err, e_cnt); end
            n_checks++; if (obs_starts !== n || obs_unstable !== 0) begin n_fail++; $display("FAIL rnd%0d_mul_ops: got starts=%0d unstable=%0d want %0d/0", j, obs_starts, obs_unstable, n); end
            n_checks++; if (obs_stall_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_stall_stable: got %0d changes want 0", j, obs_stall_bad); end
            n_checks++; if (obs_after_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_one_sum: got out_valid=%b after accept want 0", j, obs_after_valid); end
        end
    endtask

    task automatic test_reset_mid_job();
        cmd_valid = 1'b1; cmd_bias = 32'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_x = 16'd7; in_w = 16'd9; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mul: got mul_start=%b want 1", mul_start); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (mul_start !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got mul_start=%b out_valid=%b want 0/0", mul_start, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        px[0] = 1; pw[0] = 1; gap[0] = 0;
        run_job(32'd0, 1, 0);
        n_checks++; if (obs_sum !== 64'd1 || obs_cnt !== 1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL rst_new_job: got sum=%0d cnt=%0d err=%b want 1/1/0", obs_sum, obs_cnt, obs_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_timeout();
        test_done_vs_timeout();
        test_random_stall();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
